adc_capture_sequencer: RTL and testbench
========================================

Name: adc_capture_sequencer

Overview:
- Schedules periodic conversion frames on the 8-channel parallel ADC front end.
- Issues a one-cycle conversion-start strobe to the ADC driver, collects NUM_CH returned samples, tags each with its channel index, and buffers them in a FIFO toward the processing memory path.
- Supports free-run and fixed-length burst modes.
- Flags overrun, missed-tick and driver-timeout errors.

Parameters:
- NUM_CH, 8: samples per frame (one per ADC channel).
- DATA_W, 16: sample width.
- PERIOD_W, 16: width of the sample-period counter.
- FIFO_DEPTH, 16: output FIFO entries; power of two.
- TIMEOUT, 255: maximum cycles between driver samples in a frame before abort.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset; asynchronous, active-low.
- cfg_enable, input, 1: level. 1 = run; 0 = stop after the current frame.
- cfg_single, input, 1: 1 = burst mode (stop after cfg_frames frames); 0 = free-run.
- cfg_frames, input, 8: burst length. 0 is treated as 1.
- cfg_period, input, PERIOD_W: cycles between conversion starts. Values below 2 are clamped to 2.
- clr_status, input, 1: one-cycle pulse; clears the sticky error flags.
- conv_start, output, 1: one-cycle strobe to the ADC driver.
- drv_ready, input, 1: driver configured and idle.
- drv_valid, input, 1: driver sample strobe.
- drv_data, input, DATA_W: driver sample.
- out_valid, output, 1: FIFO not empty.
- out_ready, input, 1: consumer accepts the entry.
- out_data, output, DATA_W: sample.
- out_ch, output, $clog2(NUM_CH): channel tag.
- out_last, output, 1: set on the last channel of a frame.
- busy, output, 1: state is not IDLE.
- overrun, output, 1: sticky; a sample was dropped because the FIFO was full.
- missed_tick, output, 1: sticky; a period tick arrived while a start could not be issued.
- timeout_err, output, 1: sticky; a frame was aborted by the watchdog.
- frame_count, output, 16: completed frames; wraps at 0xFFFF -> 0.

Behaviour:
- Reset: state IDLE; all outputs 0; FIFO empty; counters 0.
- States:
  - IDLE -> WAIT_TICK on cfg_enable=1. On this transition: period counter loaded with 0, frames_left loaded with max(cfg_frames,1).
  - WAIT_TICK: tick occurs when the counter reaches 0; the counter then reloads max(cfg_period,2)-1.
    - Tick with drv_ready=1 -> START.
    - Tick with drv_ready=0 -> set missed_tick, stay in WAIT_TICK.
  - START: conv_start=1 for exactly one cycle; channel index cleared -> COLLECT.
  - COLLECT: each drv_valid writes {data, ch, last} into the FIFO and increments ch.
    - When ch reaches NUM_CH-1 and is written: frame_count+1.
    - Then: if (cfg_single and frames_left==1) or cfg_enable==0 -> IDLE; else frames_left-1 and -> WAIT_TICK.
- Period counter keeps running during START/COLLECT, so starts are spaced exactly cfg_period cycles apart. A tick in COLLECT sets missed_tick and is skipped.
- First conv_start: 2 cycles after cfg_enable is sampled high (IDLE->WAIT_TICK, tick, START).
- FIFO full on drv_valid: the sample is dropped, overrun is set, and ch still advances so framing stays aligned. A simultaneous pop frees no slot for that write.
- Push and pop in the same cycle on a non-full FIFO: both take effect and the occupancy is unchanged.
- Watchdog:
  - Counter cleared at START and on each drv_valid; increments in COLLECT.
  - When it reaches TIMEOUT: set timeout_err, mark the last written entry's out_last=0 unchanged, and go to WAIT_TICK (or IDLE under the stop conditions above).
  - An aborted frame does not increment frame_count.
- cfg_enable dropped mid-frame: the frame completes, then IDLE. It never truncates a frame except via the watchdog.
- drv_valid outside COLLECT: ignored; no FIFO write.
- Config inputs are sampled only at IDLE exit (mode, frames) and at each reload (period).
- clr_status in the same cycle as a new error event: the error wins and the flag stays 1.
- out_* reflect the FIFO head combinationally from registered storage. A pop occurs when out_valid and out_ready are both high.
- Async reset mid-frame: immediate return to IDLE, FIFO flushed, conv_start deasserted.

Optional Feature:
- CAPTURE_TIMESTAMP_EN defined:
  - Adds port out_stamp, output, 32: a free-running cycle counter latched at conv_start and stored with every sample of that frame.
  - FIFO width grows by 32.
- Not defined: no out_stamp port, no counter.

Decomposition:
- Package adc_capture_pkg:
  - State enum (IDLE, WAIT_TICK, START, COLLECT).
  - FIFO entry struct {data, ch, last[, stamp]}.
  - Constant CH_W=$clog2(NUM_CH).
- One sub-module: adc_sample_fifo, a synchronous FIFO with full/empty and an occupancy count.

Test Plan:
- Free-run: cfg_period=20, NUM_CH=8, driver returns 8 samples 1 cycle apart, out_ready=1 -> conv_start every 20 cycles; out_ch 0..7 with out_last on ch 7; frame_count 1,2,3...
- Burst: cfg_single=1, cfg_frames=3 -> exactly 3 conv_start pulses, frame_count=3, busy falls after the 24th sample; cfg_frames=0 -> 1 frame.
- Backpressure: out_ready=0, FIFO_DEPTH=16, 3 frames -> first 16 samples kept, remaining 8 dropped, overrun=1, frame_count=3; clr_status -> overrun=0.
- Slow driver: cfg_period=4 with samples spaced 2 cycles -> missed_tick=1; starts stay on the 4-cycle grid with no double start.
- Timeout: driver stops after 5 samples -> timeout_err=1 after 255 idle cycles, frame_count unchanged, next conv_start on the following tick.
- Reset: assert rst low during COLLECT with 6 entries queued -> out_valid=0, busy=0, conv_start=0 immediately; after release with cfg_enable=1, first conv_start 2 cycles later.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared types and constants for the ADC capture sequencer.
// Holds the FSM state encoding, the FIFO entry layout and the frame-length helper.
// Optional macro CAPTURE_TIMESTAMP_EN adds a 32-bit stamp field to every FIFO entry.
package adc_capture_pkg;

  localparam int NUM_CH  = 8;
  localparam int DATA_W  = 16;
  localparam int CH_W    = $clog2(NUM_CH);
  localparam int STAMP_W = 32;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_WAIT_TICK = 2'd1;
  localparam state_t ST_START     = 2'd2;
  localparam state_t ST_COLLECT   = 2'd3;

  typedef struct packed {
`ifdef CAPTURE_TIMESTAMP_EN
    logic [STAMP_W-1:0] stamp;
`endif
    logic [DATA_W-1:0]  data;
    logic [CH_W-1:0]    ch;
    logic               last;
  } entry_t;

  // A burst length of zero still runs one frame.
  function automatic logic [7:0] frames_norm(input logic [7:0] f);
    return (f == 8'd0) ? 8'd1 : f;
  endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// adc_sample_fifo: synchronous FIFO, registered storage, head visible combinationally.
// Latency: a pushed entry is at the head one cycle later; pop takes effect on the clock edge.
// Backpressure: a push while full is discarded even if a pop happens in the same cycle.
// Ports: i_clk, i_rst_n (async active-low), i_push/i_push_dat, i_pop,
//        o_head_dat, o_full, o_count (occupancy; empty is o_count == 0).
module adc_sample_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_dat,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head_dat,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  // Full is judged on the current occupancy, so a same-cycle pop never makes room.
  assign w_full    = (r_count == FULL_CNT);
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && (r_count != '0);

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_full     = w_full;
  assign o_count    = r_count;

endmodule

// File: rtl/adc_capture_sequencer.sv
// adc_capture_sequencer: periodic ADC frame scheduler; strobes conv_start, tags NUM_CH samples, queues them.
// Latency: first conv_start two cycles after enable is seen in IDLE; samples reach the FIFO head one cycle after drv_valid.
// Backpressure: out_valid/out_ready; a sample arriving while the FIFO is full is dropped and flagged as overrun.
// Ports: i_clk, i_rst_n (async active-low); i_cfg_* run configuration; i_clr_status clears sticky flags;
//        o_conv_start / i_drv_ready / i_drv_valid / i_drv_data to the ADC driver; o_out_* FIFO head;
//        o_busy, o_overrun, o_missed_tick, o_timeout_err, o_frame_count status.
// Optional macro CAPTURE_TIMESTAMP_EN adds o_out_stamp (cycle count latched at conv_start).
module adc_capture_sequencer
  import adc_capture_pkg::*;
#(
  parameter int PERIOD_W   = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_cfg_enable,
  input  logic                i_cfg_single,
  input  logic [7:0]          i_cfg_frames,
  input  logic [PERIOD_W-1:0] i_cfg_period,
  input  logic                i_clr_status,
  output logic                o_conv_start,
  input  logic                i_drv_ready,
  input  logic                i_drv_valid,
  input  logic [DATA_W-1:0]   i_drv_data,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic [DATA_W-1:0]   o_out_data,
  output logic [CH_W-1:0]     o_out_ch,
  output logic                o_out_last,
`ifdef CAPTURE_TIMESTAMP_EN
  output logic [STAMP_W-1:0]  o_out_stamp,
`endif
  output logic                o_busy,
  output logic                o_overrun,
  output logic                o_missed_tick,
  output logic                o_timeout_err,
  output logic [15:0]         o_frame_count
);

  localparam int WD_W    = $clog2(TIMEOUT + 1);
  localparam int FIFO_AW = $clog2(FIFO_DEPTH);

  state_t              r_state;
  logic [PERIOD_W-1:0] r_period_cnt;
  logic [7:0]          r_frames_left;
  logic                r_single;
  logic [CH_W-1:0]     r_ch;
  logic [WD_W-1:0]     r_wdog;
  logic                r_overrun;
  logic                r_missed_tick;
  logic                r_timeout_err;
  logic [15:0]         r_frame_count;

  logic [PERIOD_W-1:0] w_period_reload;
  logic                w_tick;
  logic                w_collect_vld;
  logic                w_ch_last;
  logic                w_frame_done;
  logic                w_wdog_expire;
  logic                w_frame_end;
  logic                w_stop;
  logic                w_fifo_full;
  logic [FIFO_AW:0]    w_fifo_count;
  logic                w_missed_evt;
  logic                w_overrun_evt;
  entry_t              w_entry;
  entry_t              w_head;

  // Periods below 2 would collide START with the next tick, so they are clamped.
  assign w_period_reload = (i_cfg_period < PERIOD_W'(2)) ? PERIOD_W'(1)
                                                         : i_cfg_period - PERIOD_W'(1);
  assign w_tick        = (r_state != ST_IDLE) && (r_period_cnt == '0);
  assign w_collect_vld = (r_state == ST_COLLECT) && i_drv_valid;
  assign w_ch_last     = (r_ch == CH_W'(NUM_CH - 1));
  assign w_frame_done  = w_collect_vld && w_ch_last;
  // The watchdog fires on the cycle its count would reach TIMEOUT.
  assign w_wdog_expire = (r_state == ST_COLLECT) && !i_drv_valid &&
                         (r_wdog == WD_W'(TIMEOUT - 1));
  assign w_frame_end   = w_frame_done || w_wdog_expire;
  assign w_stop        = (r_single && (r_frames_left == 8'd1)) || !i_cfg_enable;
  assign w_overrun_evt = w_collect_vld && w_fifo_full;
  assign w_missed_evt  = w_tick && ((r_state == ST_COLLECT) ||
                         ((r_state == ST_WAIT_TICK) && i_cfg_enable && !i_drv_ready));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_period_cnt  <= '0;
      r_frames_left <= '0;
      r_single      <= 1'b0;
      r_ch          <= '0;
      r_wdog        <= '0;
      r_overrun     <= 1'b0;
      r_missed_tick <= 1'b0;
      r_timeout_err <= 1'b0;
      r_frame_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_cfg_enable) begin
            r_state       <= ST_WAIT_TICK;
            r_period_cnt  <= '0;
            r_frames_left <= frames_norm(i_cfg_frames);
            r_single      <= i_cfg_single;
          end
        end
        ST_WAIT_TICK: begin
          // No frame is in flight here, so a dropped enable stops at once.
          if (!i_cfg_enable) begin
            r_state <= ST_IDLE;
          end else if (w_tick && i_drv_ready) begin
            r_state <= ST_START;
          end
        end
        ST_START: begin
          r_state <= ST_COLLECT;
          r_ch    <= '0;
          r_wdog  <= '0;
        end
        ST_COLLECT: begin
          // The channel advances even on a dropped sample to keep framing aligned.
          if (i_drv_valid) begin
            r_ch   <= r_ch + CH_W'(1);
            r_wdog <= '0;
          end else begin
            r_wdog <= r_wdog + WD_W'(1);
          end
          if (w_frame_end) begin
            if (w_stop) begin
              r_state <= ST_IDLE;
            end else begin
              r_state       <= ST_WAIT_TICK;
              r_frames_left <= r_frames_left - 8'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // The period counter free-runs through START/COLLECT to keep starts on a fixed grid.
      if (r_state != ST_IDLE) begin
        r_period_cnt <= w_tick ? w_period_reload : r_period_cnt - PERIOD_W'(1);
      end

      if (w_frame_done) r_frame_count <= r_frame_count + 16'd1;

      // A new event in the same cycle as clear keeps the flag set.
      r_overrun     <= w_overrun_evt || (r_overrun && !i_clr_status);
      r_missed_tick <= w_missed_evt  || (r_missed_tick && !i_clr_status);
      r_timeout_err <= w_wdog_expire || (r_timeout_err && !i_clr_status);
    end
  end

`ifdef CAPTURE_TIMESTAMP_EN
  logic [STAMP_W-1:0] r_free_cnt;
  logic [STAMP_W-1:0] r_stamp;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_free_cnt <= '0;
      r_stamp    <= '0;
    end else begin
      r_free_cnt <= r_free_cnt + STAMP_W'(1);
      if (r_state == ST_START) r_stamp <= r_free_cnt;
    end
  end
`endif

  always_comb begin
    w_entry      = '0;
    w_entry.data = i_drv_data;
    w_entry.ch   = r_ch;
    w_entry.last = w_ch_last;
`ifdef CAPTURE_TIMESTAMP_EN
    w_entry.stamp = r_stamp;
`endif
  end

  adc_sample_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (w_collect_vld),
    .i_push_dat (w_entry),
    .i_pop      (o_out_valid && i_out_ready),
    .o_head_dat (w_head),
    .o_full     (w_fifo_full),
    .o_count    (w_fifo_count)
  );

  assign o_out_valid   = (w_fifo_count != '0);
  assign o_out_data    = w_head.data;
  assign o_out_ch      = w_head.ch;
  assign o_out_last    = w_head.last;
`ifdef CAPTURE_TIMESTAMP_EN
  assign o_out_stamp   = w_head.stamp;
`endif
  assign o_conv_start  = (r_state == ST_START);
  assign o_busy        = (r_state != ST_IDLE);
  assign o_overrun     = r_overrun;
  assign o_missed_tick = r_missed_tick;
  assign o_timeout_err = r_timeout_err;
  assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// tb_adc_capture_sequencer: directed bench for adc_capture_sequencer.
// Drives frames from a simple driver model, records conv_start times and popped entries, compares against hand values.
// Summary line reports comparison and failure counts.
module tb_adc_capture_sequencer;
  import adc_capture_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              cfg_enable;
  logic              cfg_single;
  logic [7:0]        cfg_frames;
  logic [15:0]       cfg_period;
  logic              clr_status;
  logic              conv_start;
  logic              drv_ready;
  logic              drv_valid;
  logic [15:0]       drv_data;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_data;
  logic [CH_W-1:0]   out_ch;
  logic              out_last;
`ifdef CAPTURE_TIMESTAMP_EN
  logic [31:0]       out_stamp;
`endif
  logic              busy;
  logic              overrun;
  logic              missed_tick;
  logic              timeout_err;
  logic [15:0]       frame_count;

  adc_capture_sequencer dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_cfg_enable  (cfg_enable),
    .i_cfg_single  (cfg_single),
    .i_cfg_frames  (cfg_frames),
    .i_cfg_period  (cfg_period),
    .i_clr_status  (clr_status),
    .o_conv_start  (conv_start),
    .i_drv_ready   (drv_ready),
    .i_drv_valid   (drv_valid),
    .i_drv_data    (drv_data),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_out_data    (out_data),
    .o_out_ch      (out_ch),
    .o_out_last    (out_last),
`ifdef CAPTURE_TIMESTAMP_EN
    .o_out_stamp   (out_stamp),
`endif
    .o_busy        (busy),
    .o_overrun     (overrun),
    .o_missed_tick (missed_tick),
    .o_timeout_err (timeout_err),
    .o_frame_count (frame_count)
  );

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int n_start = 0;
  logic [15:0]     q_dat  [$];
  logic [CH_W-1:0] q_ch   [$];
  logic            q_last [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe just after the falling edge, once the stimulus for this cycle has settled.
  always @(negedge clk) begin
    #1;
    if (conv_start) n_start++;
    if (out_valid && out_ready) begin
      q_dat.push_back(out_data);
      q_ch.push_back(out_ch);
      q_last.push_back(out_last);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_start(input string tag, output int t);
    t = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (conv_start) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) chk({tag, "_no_start"}, 32'd0, 32'd1);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Called at the negedge of the START cycle; the first sample lands in COLLECT.
  task automatic drive_frame(input int n, input int gap, input logic [7:0] tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drv_valid = 1'b1;
      drv_data  = {tag, 8'(i)};
      for (int g = 1; g < gap; g++) begin
        @(negedge clk);
        drv_valid = 1'b0;
      end
    end
    @(negedge clk);
    drv_valid = 1'b0;
  endtask

  task automatic check_entries(input int base, input int nfr, input logic [7:0] tag0, input string tag);
    for (int j = 0; j < nfr * NUM_CH; j++) begin
      int f;
      int i;
      logic [15:0] exp_d;
      f = j / NUM_CH;
      i = j % NUM_CH;
      exp_d = {8'(int'(tag0) + f), 8'(i)};
      if (base + j < q_dat.size()) begin
        chk({tag, "_data"}, 32'(q_dat[base + j]), 32'(exp_d));
        chk({tag, "_ch"}, 32'(q_ch[base + j]), 32'(i));
        chk({tag, "_last"}, 32'(q_last[base + j]), (i == NUM_CH - 1) ? 32'd1 : 32'd0);
      end else begin
        chk({tag, "_missing"}, 32'd0, 32'd1);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_time_limit: got=expired exp=finish");
    $fatal(1, "time limit");
  end

  initial begin
    int t0;
    int q0;
    int ns0;
    int ts [3];

    rst_n = 1'b0; cfg_enable = 1'b0; cfg_single = 1'b0; cfg_frames = 8'd0;
    cfg_period = 16'd20; clr_status = 1'b0; drv_ready = 1'b1; drv_valid = 1'b0;
    drv_data = 16'h0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_conv_start", 32'(conv_start), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_missed", 32'(missed_tick), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Driver samples while idle must not reach the FIFO.
    drv_valid = 1'b1; drv_data = 16'hDEAD;
    repeat (3) @(negedge clk);
    drv_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_drv_out_valid", 32'(out_valid), 32'd0);
    chk("idle_drv_busy", 32'(busy), 32'd0);

    // Free-run, period 20, back-to-back samples.
    q0 = q_dat.size();
    t0 = cyc;
    cfg_enable = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_start("fr", ts[f]);
      drive_frame(8, 1, 8'(8'h10 + f));
      chk("fr_frame_count", 32'(frame_count), 32'(f + 1));
    end
    chk("fr_first_latency", 32'(ts[0] - t0), 32'd2);
    chk("fr_spacing_a", 32'(ts[1] - ts[0]), 32'd20);
    chk("fr_spacing_b", 32'(ts[2] - ts[1]), 32'd20);
    cfg_enable = 1'b0;
    repeat (4) @(negedge clk);
    chk("fr_busy_off", 32'(busy), 32'd0);
    chk("fr_missed", 32'(missed_tick), 32'd0);
    chk("fr_pops", 32'(q_dat.size() - q0), 32'd24);
    check_entries(q0, 3, 8'h10, "fr");

    // Burst of three frames.
    ns0 = n_start;
    cfg_single = 1'b1; cfg_frames = 8'd3; cfg_enable = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_start("bu", ts[f]);
      drive_frame(8, 1, 8'(8'h20 + f));
    end
    chk("bu_busy_fall", 32'(busy), 32'd0);
    cfg_enable = 1'b0;
    chk("bu_frame_count", 32'(frame_count), 32'd6);
    repeat (40) @(negedge clk);
    chk("bu_starts", 32'(n_start - ns0), 32'd3);

    // Burst length 0 runs a single frame.
    ns0 = n_start;
    cfg_frames = 8'd0; cfg_enable = 1'b1;
    wait_start("b0", ts[0]);
    drive_frame(8, 1, 8'h30);
    chk("b0_busy_fall", 32'(busy), 32'd0);
    cfg_enable = 1'b0;
    repeat (40) @(negedge clk);
    chk("b0_starts", 32'(n_start - ns0), 32'd1);
    chk("b0_frame_count", 32'(frame_count), 32'd7);

    // Backpressure: 24 samples into a 16-entry FIFO.
    out_ready = 1'b0; cfg_frames = 8'd3; cfg_enable = 1'b1;
    wait_start("bp", ts[0]);
    drive_frame(8, 1, 8'h40);
    wait_start("bp", ts[1]);
    drive_frame(8, 1, 8'h41);
    chk("bp_no_overrun_at_16", 32'(overrun), 32'd0);
    chk("bp_valid", 32'(out_valid), 32'd1);
    wait_start("bp", ts[2]);
    drive_frame(8, 1, 8'h42);
    chk("bp_overrun", 32'(overrun), 32'd1);
    chk("bp_frame_count", 32'(frame_count), 32'd10);
    chk("bp_busy_fall", 32'(busy), 32'd0);
    cfg_enable = 1'b0;
    q0 = q_dat.size();
    out_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("bp_drained", 32'(q_dat.size() - q0), 32'd16);
    check_entries(q0, 2, 8'h40, "bp");
    chk("bp_empty", 32'(out_valid), 32'd0);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    chk("bp_clr_overrun", 32'(overrun), 32'd0);

    // Slow driver: period 4, samples every 2 cycles.
    chk("sd_missed_pre", 32'(missed_tick), 32'd0);
    ns0 = n_start;
    cfg_single = 1'b0; cfg_period = 16'd4; cfg_enable = 1'b1;
    wait_start("sd", ts[0]);
    drive_frame(8, 2, 8'h50);
    wait_start("sd", ts[1]);
    drive_frame(8, 2, 8'h51);
    cfg_enable = 1'b0;
    chk("sd_spacing", 32'(ts[1] - ts[0]), 32'd20);
    chk("sd_missed", 32'(missed_tick), 32'd1);
    chk("sd_frame_count", 32'(frame_count), 32'd12);
    repeat (10) @(negedge clk);
    chk("sd_starts", 32'(n_start - ns0), 32'd2);

    // Watchdog: only 5 samples arrive.
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    chk("to_missed_cleared", 32'(missed_tick), 32'd0);
    cfg_period = 16'd20; cfg_enable = 1'b1;
    wait_start("to", ts[0]);
    drive_frame(5, 1, 8'h60);
    wait_until(ts[0] + 260);
    chk("to_flag_before", 32'(timeout_err), 32'd0);
    @(negedge clk);
    chk("to_flag_set", 32'(timeout_err), 32'd1);
    chk("to_frame_count", 32'(frame_count), 32'd12);
    wait_start("to", ts[1]);
    chk("to_next_start", 32'(ts[1] - ts[0]), 32'd280);
    drive_frame(8, 1, 8'h61);
    cfg_enable = 1'b0;
    chk("to_frame_after", 32'(frame_count), 32'd13);
    repeat (4) @(negedge clk);

    // Asynchronous reset mid-frame with 6 entries queued.
    out_ready = 1'b0; cfg_enable = 1'b1;
    wait_start("rs", ts[0]);
    drive_frame(6, 1, 8'h70);
    chk("rs_valid_pre", 32'(out_valid), 32'd1);
    chk("rs_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rs_out_valid", 32'(out_valid), 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_conv_start", 32'(conv_start), 32'd0);
    chk("rs_frame_count", 32'(frame_count), 32'd0);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    q0 = q_dat.size();
    t0 = cyc;
    rst_n = 1'b1;
    wait_start("rs", ts[1]);
    chk("rs_first_latency", 32'(ts[1] - t0), 32'd2);
    drive_frame(8, 1, 8'h71);
    cfg_enable = 1'b0;
    chk("rs_frame_after", 32'(frame_count), 32'd1);
    repeat (4) @(negedge clk);
    chk("rs_pops", 32'(q_dat.size() - q0), 32'd8);
    check_entries(q0, 1, 8'h71, "rs");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
